oflow_mem_buffer_ctrl: RTL and testbench

Per-frame sequencer sitting directly upstream of `oflow_mem_buffer_wrapper`, generating all its control strobes. On each frame start it runs a read phase (history features streamed line-by-line to the similarity metric) and then a write phase (current-frame PE features committed two bboxes per beat). It paces write beats to the buffer's 3-cycle data latency and reports frame completion to the top-level core FSM.

---
 rtl/oflow_mem_ctrl_pkg.sv | 21 ++
 rtl/oflow_mem_buffer_ctrl_if.sv | 45 ++++
 rtl/oflow_mem_ctrl_beat_pacer.sv | 47 ++++
 rtl/oflow_mem_buffer_ctrl.sv | 155 +++++++++++++++
 tb/tb_oflow_mem_buffer_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/oflow_mem_ctrl_pkg.sv
// Shared types and default sizes for the MEM buffer control sequencer.
// The width defaults track the oflow MEM buffer defines.
package oflow_mem_ctrl_pkg;

  localparam int TOTAL_FRAME_NUM_WIDTH_DEF       = 8;
  localparam int NUM_OF_HISTORY_FRAMES_WIDTH_DEF = 3;
  localparam int NUM_OF_BBOX_IN_FRAME_WIDTH_DEF  = 6;
  localparam int BEAT_GAP_DEF                    = 4;
  localparam int WDOG_CYCLES_DEF                 = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_START,
    ST_RD_LINES,
    ST_WR_START,
    ST_WR_BEATS,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/oflow_mem_buffer_ctrl_if.sv
// Control bundle between the frame sequencer (slave) and its environment (master).
// Also carries the sequencer state for observation.
interface oflow_mem_buffer_ctrl_if
  import oflow_mem_ctrl_pkg::*;
#(
  parameter int TOTAL_FRAME_NUM_WIDTH      = TOTAL_FRAME_NUM_WIDTH_DEF,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH = NUM_OF_BBOX_IN_FRAME_WIDTH_DEF
);

  // Every control line is a strobe sampled on the rising clock edge. There is
  // no backpressure: a strobe is consumed in the cycle it is seen, or dropped
  // where the sequencer's current state does not use it.
  logic                                  start_frame;
  logic [TOTAL_FRAME_NUM_WIDTH-1:0]      frame_num;
  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] num_of_bbox_in_frame;
  logic                                  sim_line_done;
  logic                                  pe_data_valid;
  logic                                  done_read;
  logic                                  done_write;
  logic                                  start_read;
  logic                                  start_write;
  logic                                  read_new_line;
  logic                                  ready_from_core;
  logic                                  rnw_st;
  logic                                  busy;
  logic                                  frame_done;
  logic                                  beat_ovf_err;
  logic                                  wdog_err;
  state_t                                state;

  modport slave (
    input  start_frame, frame_num, num_of_bbox_in_frame, sim_line_done,
           pe_data_valid, done_read, done_write,
    output start_read, start_write, read_new_line, ready_from_core, rnw_st,
           busy, frame_done, beat_ovf_err, wdog_err, state
  );

  modport master (
    output start_frame, frame_num, num_of_bbox_in_frame, sim_line_done,
           pe_data_valid, done_read, done_write,
    input  start_read, start_write, read_new_line, ready_from_core, rnw_st,
           busy, frame_done, beat_ovf_err, wdog_err, state
  );

endinterface

// File: rtl/oflow_mem_ctrl_beat_pacer.sv
// Spaces write-beat strobes at least BEAT_GAP cycles apart, holding one early
// beat in a pending slot and flagging any beat that finds the slot full.
module oflow_mem_ctrl_beat_pacer
  import oflow_mem_ctrl_pkg::*;
#(
  parameter int BEAT_GAP = BEAT_GAP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid,
  output logic pulse,
  output logic ovf_err
);

  localparam int GW = $clog2(BEAT_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(BEAT_GAP - 1);

  logic [GW-1:0] gap;
  logic          pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap     <= '0;
      pending <= 1'b0;
      pulse   <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (gap != '0) gap <= gap - 1'b1;
      // The gap keeps draining outside the write phase so spacing holds across frames.
      if (!enable) begin
        pending <= 1'b0;
      end else if (gap == '0) begin
        if (pending || valid) begin
          pulse   <= 1'b1;
          gap     <= GAP_LOAD;
          pending <= pending && valid;
        end
      end else if (valid) begin
        if (pending) ovf_err <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/oflow_mem_buffer_ctrl.sv
// Per-frame read-then-write sequencer driving the oflow MEM buffer strobes.
// Define OFLOW_MEM_CTRL_WDOG_EN to build the stall watchdog.
module oflow_mem_buffer_ctrl
  import oflow_mem_ctrl_pkg::*;
#(
  parameter int TOTAL_FRAME_NUM_WIDTH       = TOTAL_FRAME_NUM_WIDTH_DEF,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = NUM_OF_HISTORY_FRAMES_WIDTH_DEF,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = NUM_OF_BBOX_IN_FRAME_WIDTH_DEF,
  parameter int BEAT_GAP                    = BEAT_GAP_DEF,
  parameter int WDOG_CYCLES                 = WDOG_CYCLES_DEF
) (
  input logic                     clk,
  input logic                     reset,
  oflow_mem_buffer_ctrl_if.slave  bus
);

  localparam int NB = NUM_OF_BBOX_IN_FRAME_WIDTH;

  if (NUM_OF_HISTORY_FRAMES_WIDTH < 1 || TOTAL_FRAME_NUM_WIDTH < 1 ||
      BEAT_GAP < 1 || WDOG_CYCLES < 2) begin : g_param_check
    $error("oflow_mem_buffer_ctrl: illegal parameter value");
  end

  state_t        state;
  logic [NB-1:0] bbox_q;
  logic [NB-1:0] bbox_plus;
  logic [NB-1:0] beat_target;
  logic [NB-1:0] beat_cnt;
  logic          done_wr_seen;

  // Wraps at NB bits, so a full-scale bbox count yields a zero-beat target.
  assign bbox_plus = bbox_q + 1'b1;
  assign bus.state = state;

  oflow_mem_ctrl_beat_pacer #(.BEAT_GAP(BEAT_GAP)) u_pacer (
    .clk     (clk),
    .reset   (reset),
    .enable  (state == ST_WR_BEATS),
    .valid   (bus.pe_data_valid),
    .pulse   (bus.ready_from_core),
    .ovf_err (bus.beat_ovf_err)
  );

`ifdef OFLOW_MEM_CTRL_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wdog_cnt;
  logic          wdog_trip;

  assign wdog_trip = (state == ST_RD_LINES || state == ST_WR_WAIT) &&
                     (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdog_cnt <= '0;
    else if (!(state == ST_RD_LINES || state == ST_WR_WAIT) ||
             bus.read_new_line || bus.ready_from_core)
      wdog_cnt <= '0;
    else
      wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  assign bus.wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      bbox_q          <= '0;
      beat_target     <= '0;
      beat_cnt        <= '0;
      done_wr_seen    <= 1'b0;
      bus.start_read  <= 1'b0;
      bus.start_write <= 1'b0;
      bus.read_new_line <= 1'b0;
      bus.rnw_st      <= 1'b1;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
`ifdef OFLOW_MEM_CTRL_WDOG_EN
      bus.wdog_err    <= 1'b0;
`endif
    end else begin
      bus.start_read    <= 1'b0;
      bus.start_write   <= 1'b0;
      bus.read_new_line <= 1'b0;
      bus.frame_done    <= 1'b0;
      if ((state == ST_WR_START || state == ST_WR_BEATS) && bus.done_write)
        done_wr_seen <= 1'b1;

      case (state)
        ST_IDLE: if (bus.start_frame) begin
          bbox_q       <= bus.num_of_bbox_in_frame;
          done_wr_seen <= 1'b0;
          bus.busy     <= 1'b1;
          // Frame 0 has no history to read.
          if (bus.frame_num == '0) begin
            state           <= ST_WR_START;
            bus.rnw_st      <= 1'b0;
            bus.start_write <= (bus.num_of_bbox_in_frame != '0);
          end else begin
            state          <= ST_RD_START;
            bus.start_read <= 1'b1;
          end
        end
        ST_RD_START: state <= ST_RD_LINES;
        ST_RD_LINES: begin
          if (bus.done_read) begin
            state           <= ST_WR_START;
            bus.rnw_st      <= 1'b0;
            bus.start_write <= (bbox_q != '0);
          end else if (bus.sim_line_done) begin
            bus.read_new_line <= 1'b1;
          end
        end
        ST_WR_START: begin
          beat_cnt <= '0;
          if (bbox_q == '0) begin
            state          <= ST_DONE;
            bus.rnw_st     <= 1'b1;
            bus.frame_done <= 1'b1;
          end else begin
            state       <= ST_WR_BEATS;
            beat_target <= bbox_plus >> 1;
          end
        end
        ST_WR_BEATS: begin
          if (beat_cnt == beat_target)  state    <= ST_WR_WAIT;
          else if (bus.ready_from_core) beat_cnt <= beat_cnt + 1'b1;
        end
        ST_WR_WAIT: if (bus.done_write || done_wr_seen) begin
          state          <= ST_DONE;
          bus.rnw_st     <= 1'b1;
          bus.frame_done <= 1'b1;
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          bus.busy     <= 1'b0;
          done_wr_seen <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

`ifdef OFLOW_MEM_CTRL_WDOG_EN
      if (wdog_trip) begin
        state             <= ST_DONE;
        bus.rnw_st        <= 1'b1;
        bus.frame_done    <= 1'b1;
        bus.start_write   <= 1'b0;
        bus.read_new_line <= 1'b0;
        bus.wdog_err      <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_oflow_mem_buffer_ctrl.sv
// Vector-table bench for oflow_mem_buffer_ctrl; builds with or without
// OFLOW_MEM_CTRL_WDOG_EN (watchdog limit set to 16 here).
module tb_oflow_mem_buffer_ctrl;
  import oflow_mem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oflow_mem_buffer_ctrl_if #(
    .TOTAL_FRAME_NUM_WIDTH(8), .NUM_OF_BBOX_IN_FRAME_WIDTH(6)
  ) bus ();

  oflow_mem_buffer_ctrl #(
    .TOTAL_FRAME_NUM_WIDTH(8), .NUM_OF_HISTORY_FRAMES_WIDTH(3),
    .NUM_OF_BBOX_IN_FRAME_WIDTH(6), .BEAT_GAP(4), .WDOG_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Output word: {start_read, start_write, read_new_line, ready_from_core,
  //               rnw_st, busy, frame_done, beat_ovf_err}
  typedef struct {
    logic       sf;
    logic [7:0] fn;
    logic [5:0] nb;
    logic       sld, pdv, dr, dw;
    logic [7:0] e;
    int         reps;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         vec_no   = 0;
  int         cyc      = 0;
  int         last_pulse = -1;

  // ---------------- scoreboard ----------------
  function automatic logic [7:0] out_word();
    return {bus.start_read, bus.start_write, bus.read_new_line, bus.ready_from_core,
            bus.rnw_st, bus.busy, bus.frame_done, bus.beat_ovf_err};
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, want);
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, want);
  endtask

  // Independent spacing check on every issued write beat.
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset) last_pulse = -1;
    else if (bus.ready_from_core) begin
      if (last_pulse >= 0) begin
        n_checks++;
        if (cyc - last_pulse >= 4) n_pass++;
        else $display("FAIL beat_gap: got %0d cycles, expected >= 4", cyc - last_pulse);
      end
      last_pulse = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add(input logic sf, input logic [7:0] fn, input logic [5:0] nb,
                     input logic sld, input logic pdv, input logic dr, input logic dw,
                     input logic [7:0] e, input int reps = 1);
    vec_t v;
    v.sf = sf; v.fn = fn; v.nb = nb; v.sld = sld; v.pdv = pdv; v.dr = dr; v.dw = dw;
    v.e = e; v.reps = reps;
    tbl.push_back(v);
  endtask

  task automatic idl(input logic [7:0] e, input int reps = 1);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, e, reps);
  endtask

  task automatic pdv(input logic [7:0] e);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic zero_inputs();
    bus.start_frame = 1'b0; bus.frame_num = '0; bus.num_of_bbox_in_frame = '0;
    bus.sim_line_done = 1'b0; bus.pe_data_valid = 1'b0;
    bus.done_read = 1'b0; bus.done_write = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    logic [7:0] want;
    @(negedge clk);
    bus.start_frame = v.sf; bus.frame_num = v.fn; bus.num_of_bbox_in_frame = v.nb;
    bus.sim_line_done = v.sld; bus.pe_data_valid = v.pdv;
    bus.done_read = v.dr; bus.done_write = v.dw;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check8($sformatf("vec%0d", vec_no), out_word(), want);
    vec_no++;
  endtask

  task automatic run_table();
    foreach (tbl[i])
      for (int r = 0; r < tbl[i].reps; r++) apply(tbl[i]);
    tbl.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] fn_rand;
    fn_rand = 8'($urandom_range(1, 255));
    reset = 1'b1;
    zero_inputs();
    repeat (2) @(negedge clk);
    check8("reset_out", out_word(), 8'b0000_1000);
    check1("reset_wdog", bus.wdog_err, 1'b0);
    check1("reset_state", bus.state == ST_IDLE, 1'b1);
    reset = 1'b0;

    // Frame 0, 8 bboxes: write only, 4 beats spaced 5 apart.
    idl(8'b0000_1000, 2);
    add(1'b1, 8'd0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0100);
    idl(8'b0000_0100);
    for (int b = 0; b < 4; b++) begin
      pdv(8'b0001_0100);
      idl(8'b0000_0100, 4);
    end
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_1110);
    idl(8'b0000_1000);

    // Nonzero frame, 8 bboxes: read 3 lines, start_frame while busy ignored.
    add(1'b1, fn_rand, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1100);
    idl(8'b0000_1100);
    add(1'b1, 8'd0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_1100);
    for (int l = 0; l < 3; l++) begin
      add(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0010_1100);
      idl(8'b0000_1100);
    end
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0100_0100);
    idl(8'b0000_0100);
    for (int b = 0; b < 4; b++) begin
      pdv(8'b0001_0100);
      idl(8'b0000_0100, 4);
    end
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_1110);
    idl(8'b0000_1000);

    // Frame 2, 5 bboxes (3 beats): back-to-back valids, overflow, early done_write.
    add(1'b1, 8'd2, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1100);
    idl(8'b0000_1100);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0100_0100);
    idl(8'b0000_0100);
    pdv(8'b0001_0100);
    pdv(8'b0000_0100);
    pdv(8'b0000_0101);
    idl(8'b0000_0101);
    idl(8'b0001_0101);
    idl(8'b0000_0101, 3);
    pdv(8'b0001_0101);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0101);
    idl(8'b0000_0101);
    idl(8'b0000_1111);
    idl(8'b0000_1001);
    pdv(8'b0000_1001);

    // Same-cycle done_read/sim_line_done, 0 bboxes: no pulse, no start_write.
    add(1'b1, 8'd3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1101);
    idl(8'b0000_1101);
    add(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0000_0101);
    idl(8'b0000_1111);
    idl(8'b0000_1001);

    // Into WR_BEATS, then reset mid-frame.
    add(1'b1, 8'd0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0101);
    idl(8'b0000_0101);
    pdv(8'b0001_0101);
    run_table();

    @(negedge clk);
    reset = 1'b1;
    zero_inputs();
    #1;
    check8("mid_reset_out", out_word(), 8'b0000_1000);
    check1("mid_reset_state", bus.state == ST_IDLE, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Normal 1-bbox frame after reset.
    idl(8'b0000_1000);
    add(1'b1, 8'd5, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1100);
    idl(8'b0000_1100);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0100_0100);
    idl(8'b0000_0100);
    pdv(8'b0001_0100);
    idl(8'b0000_0100, 2);
    add(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_1110);
    idl(8'b0000_1000);
    run_table();
    check1("wdog_idle", bus.wdog_err, 1'b0);

`ifdef OFLOW_MEM_CTRL_WDOG_EN
    // done_read withheld: watchdog forces DONE after 16 stalled cycles.
    add(1'b1, 8'd6, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1100);
    idl(8'b0000_1100);
    idl(8'b0000_1100, 15);
    idl(8'b0000_1110);
    idl(8'b0000_1000);
    run_table();
    check1("wdog_err", bus.wdog_err, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
